// File: rtl/nebula_vc_credit_ctrl.sv
// Per-VC credit tracker for one NoC output link: gates flit sends, absorbs batched credit returns.
// Optional saturating statistics counters are built only when NEBULA_CREDIT_STATS_EN is defined.
module nebula_vc_credit_ctrl #(
    parameter int unsigned NUM_VCS      = 4,
    parameter int unsigned VC_CREDITS   = 4,
    parameter int unsigned RET_MAX      = 2,
    parameter int unsigned CREDIT_WIDTH = $clog2(VC_CREDITS + 1),
    parameter int unsigned VC_W         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    parameter int unsigned RET_W        = $clog2(RET_MAX + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            send_valid,
    input  logic [VC_W-1:0]                 send_vc,
    output logic                            send_accept,
    input  logic                            ret_valid,
    input  logic [VC_W-1:0]                 ret_vc,
    input  logic [RET_W-1:0]                ret_cnt,
    output logic [NUM_VCS-1:0]              vc_avail,
    output logic [NUM_VCS*CREDIT_WIDTH-1:0] credit_count,
    output logic                            link_idle,
    output logic                            err_underflow,
    output logic                            err_overflow,
    input  logic                            err_clear,
    output logic [31:0]                     stat_stall_cycles,
    output logic [31:0]                     stat_flits_sent
);

    // Wide enough to hold credits + max return without wrapping before the clamp.
    localparam int unsigned SUM_W = CREDIT_WIDTH + RET_W + 1;
    localparam logic [CREDIT_WIDTH-1:0] FULL      = CREDIT_WIDTH'(VC_CREDITS);
    localparam logic [SUM_W-1:0]        FULL_EXT  = SUM_W'(VC_CREDITS);
    localparam logic [RET_W-1:0]        RET_LIMIT = RET_W'(RET_MAX);

    logic [CREDIT_WIDTH-1:0] credits_q [NUM_VCS];
    logic [CREDIT_WIDTH-1:0] credits_d [NUM_VCS];

    logic link_idle_q;
    logic link_idle_d;
    logic err_underflow_q;
    logic err_underflow_d;
    logic err_overflow_q;
    logic err_overflow_d;

    logic send_vc_ok;
    logic ret_vc_ok;
    logic ret_cnt_ok;
    logic send_has_credit;
    logic underflow_evt;
    logic range_evt;
    logic sat_evt;

    assign send_vc_ok = 32'(send_vc) < NUM_VCS;
    assign ret_vc_ok  = 32'(ret_vc) < NUM_VCS;
    assign ret_cnt_ok = ret_cnt <= RET_LIMIT;

    // Accept decision uses the current count only; a same-cycle return cannot enable a send.
    always_comb begin
        send_has_credit = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (send_vc == VC_W'(v) && credits_q[v] != '0) begin
                send_has_credit = 1'b1;
            end
        end
    end

    assign send_accept   = send_valid && send_has_credit;
    assign underflow_evt = send_valid && send_vc_ok && !send_has_credit;
    assign range_evt     = (send_valid && !send_vc_ok) ||
                           (ret_valid && (!ret_cnt_ok || !ret_vc_ok));

    always_comb begin
        logic [SUM_W-1:0] sum;
        logic [RET_W-1:0] inc;
        logic             dec;
        sum         = '0;
        inc         = '0;
        dec         = 1'b0;
        sat_evt     = 1'b0;
        link_idle_d = 1'b1;
        for (int v = 0; v < NUM_VCS; v++) begin
            dec = send_accept && (send_vc == VC_W'(v));
            inc = (ret_valid && ret_cnt_ok && ret_vc == VC_W'(v)) ? ret_cnt : '0;
            sum = SUM_W'(credits_q[v]) + SUM_W'(inc) - SUM_W'(dec);
            if (sum > FULL_EXT) begin
                credits_d[v] = FULL;
                sat_evt      = 1'b1;
            end else begin
                credits_d[v] = sum[CREDIT_WIDTH-1:0];
            end
            if (credits_d[v] != FULL) begin
                link_idle_d = 1'b0;
            end
        end
    end

    // Clear wins over a same-cycle set; a persisting condition re-sets the flag a cycle later.
    always_comb begin
        if (err_clear) begin
            err_underflow_d = 1'b0;
            err_overflow_d  = 1'b0;
        end else begin
            err_underflow_d = err_underflow_q | underflow_evt;
            err_overflow_d  = err_overflow_q | range_evt | sat_evt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                credits_q[v] <= FULL;
            end
            link_idle_q     <= 1'b1;
            err_underflow_q <= 1'b0;
            err_overflow_q  <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                credits_q[v] <= credits_d[v];
            end
            link_idle_q     <= link_idle_d;
            err_underflow_q <= err_underflow_d;
            err_overflow_q  <= err_overflow_d;
        end
    end

    always_comb begin
        vc_avail     = '0;
        credit_count = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            vc_avail[v]                                    = credits_q[v] != '0;
            credit_count[v*CREDIT_WIDTH +: CREDIT_WIDTH]   = credits_q[v];
        end
    end

    assign link_idle     = link_idle_q;
    assign err_underflow = err_underflow_q;
    assign err_overflow  = err_overflow_q;

`ifdef NEBULA_CREDIT_STATS_EN
    logic [31:0] stall_q;
    logic [31:0] stall_d;
    logic [31:0] flits_q;
    logic [31:0] flits_d;

    always_comb begin
        stall_d = stall_q;
        flits_d = flits_q;
        if (send_valid && !send_accept && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
        if (send_accept && flits_q != '1) begin
            flits_d = flits_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flits_q <= '0;
        end else begin
            stall_q <= stall_d;
            flits_q <= flits_d;
        end
    end

    assign stat_stall_cycles = stall_q;
    assign stat_flits_sent   = flits_q;
`else
    assign stat_stall_cycles = '0;
    assign stat_flits_sent   = '0;
`endif

endmodule

// File: tb/tb_nebula_vc_credit_ctrl.sv
// Scoreboard bench for nebula_vc_credit_ctrl: directed scenarios plus random traffic
// checked against an integer credit model.
module tb_nebula_vc_credit_ctrl;

    localparam int NV = 4;
    localparam int CR = 4;
    localparam int RM = 2;
    localparam int CW = 3;
    localparam int VW = 2;
    localparam int RW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            send_valid = 1'b0;
    logic [VW-1:0]   send_vc = '0;
    logic            send_accept;
    logic            ret_valid = 1'b0;
    logic [VW-1:0]   ret_vc = '0;
    logic [RW-1:0]   ret_cnt = '0;
    logic [NV-1:0]   vc_avail;
    logic [NV*CW-1:0] credit_count;
    logic            link_idle;
    logic            err_underflow;
    logic            err_overflow;
    logic            err_clear = 1'b0;
    logic [31:0]     stat_stall_cycles;
    logic [31:0]     stat_flits_sent;

    nebula_vc_credit_ctrl #(
        .NUM_VCS    (NV),
        .VC_CREDITS (CR),
        .RET_MAX    (RM)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .send_valid        (send_valid),
        .send_vc           (send_vc),
        .send_accept       (send_accept),
        .ret_valid         (ret_valid),
        .ret_vc            (ret_vc),
        .ret_cnt           (ret_cnt),
        .vc_avail          (vc_avail),
        .credit_count      (credit_count),
        .link_idle         (link_idle),
        .err_underflow     (err_underflow),
        .err_overflow      (err_overflow),
        .err_clear         (err_clear),
        .stat_stall_cycles (stat_stall_cycles),
        .stat_flits_sent   (stat_flits_sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             acc;
        logic [NV*CW-1:0] cnt;
        logic [NV-1:0]    avail;
        logic             idle;
        logic             eu;
        logic             eo;
        logic [31:0]      stall;
        logic [31:0]      flits;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integer credits per VC plus flags and counters.
    int cr[NV];
    int m_eu;
    int m_eo;
    int m_stall;
    int m_flits;

    task automatic model_reset();
        for (int v = 0; v < NV; v++) cr[v] = CR;
        m_eu    = 0;
        m_eo    = 0;
        m_stall = 0;
        m_flits = 0;
    endtask

    function automatic exp_t snapshot(input logic acc);
        exp_t e;
        e.acc  = acc;
        e.cnt  = '0;
        e.idle = 1'b1;
        for (int v = 0; v < NV; v++) begin
            e.cnt[v*CW +: CW] = 3'(cr[v]);
            e.avail[v]        = cr[v] > 0;
            if (cr[v] != CR) e.idle = 1'b0;
        end
        e.eu    = m_eu != 0;
        e.eo    = m_eo != 0;
        e.stall = 32'(m_stall);
        e.flits = 32'(m_flits);
        return e;
    endfunction

    // One cycle: drive inputs, queue the expected view for this cycle, then advance the model.
    task automatic cycle(input bit sv, input int svc, input bit rv, input int rvc,
                         input int rc, input bit clr);
        bit acc;
        bit uf;
        bit of;
        @(negedge clk);
        send_valid = sv;
        send_vc    = VW'(svc);
        ret_valid  = rv;
        ret_vc     = VW'(rvc);
        ret_cnt    = RW'(rc);
        err_clear  = clr;
        acc = sv && cr[svc] > 0;
        uf  = sv && cr[svc] == 0;
        of  = rv && rc > RM;
        exp_q.push_back(snapshot(acc));
        if (acc) cr[svc] = cr[svc] - 1;
        if (rv && rc <= RM) begin
            cr[rvc] = cr[rvc] + rc;
            if (cr[rvc] > CR) begin
                cr[rvc] = CR;
                of      = 1'b1;
            end
        end
        if (clr) begin
            m_eu = 0;
            m_eo = 0;
        end else begin
            if (uf) m_eu = 1;
            if (of) m_eo = 1;
        end
`ifdef NEBULA_CREDIT_STATS_EN
        if (acc) m_flits++;
        if (sv && !acc) m_stall++;
`endif
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic wait_drain();
        int waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        #3;
    endtask

    task automatic do_reset();
        wait_drain();
        @(negedge clk);
        send_valid = 1'b0;
        ret_valid  = 1'b0;
        err_clear  = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: registered outputs reflect the previous edge, send_accept the current inputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("send_accept", 32'(send_accept), 32'(e.acc));
                check("credit_count", 32'(credit_count), 32'(e.cnt));
                check("vc_avail", 32'(vc_avail), 32'(e.avail));
                check("link_idle", 32'(link_idle), 32'(e.idle));
                check("err_underflow", 32'(err_underflow), 32'(e.eu));
                check("err_overflow", 32'(err_overflow), 32'(e.eo));
                check("stat_stall_cycles", stat_stall_cycles, e.stall);
                check("stat_flits_sent", stat_flits_sent, e.flits);
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state, then drain VC2 and overdraw it.
        idle_cycle();
        repeat (4) cycle(1'b1, 2, 1'b0, 0, 0, 1'b0);
        cycle(1'b1, 2, 1'b0, 0, 0, 1'b0);
        idle_cycle();

        // Mid-operation reset restores full credits.
        do_reset();
        idle_cycle();

        // Same-cycle send+return on VC1.
        repeat (2) cycle(1'b1, 1, 1'b0, 0, 0, 1'b0);
        cycle(1'b1, 1, 1'b1, 1, 2, 1'b0);
        repeat (3) cycle(1'b1, 1, 1'b0, 0, 0, 1'b0);
        cycle(1'b1, 1, 1'b1, 1, 1, 1'b0);
        idle_cycle();

        // Overflow clamp on VC0, then clear.
        do_reset();
        cycle(1'b1, 0, 1'b0, 0, 0, 1'b0);
        cycle(1'b0, 0, 1'b1, 0, 2, 1'b0);
        idle_cycle();
        cycle(1'b0, 0, 1'b0, 0, 0, 1'b1);
        idle_cycle();
        // ret_cnt above the limit is rejected; ret_cnt of zero is harmless.
        cycle(1'b0, 0, 1'b1, 0, 0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1, 3, 1'b0);
        idle_cycle();

        // Independence of send and return on different VCs.
        do_reset();
        cycle(1'b1, 0, 1'b0, 0, 0, 1'b0);
        cycle(1'b1, 3, 1'b1, 0, 1, 1'b0);
        idle_cycle();

        // Statistics: 4 accepted then 3 blocked on VC2.
        do_reset();
        repeat (4) cycle(1'b1, 2, 1'b0, 0, 0, 1'b0);
        repeat (3) cycle(1'b1, 2, 1'b0, 0, 0, 1'b0);
        idle_cycle();

        // Random traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, NV - 1),
                  $urandom_range(0, 1) == 1, $urandom_range(0, NV - 1),
                  $urandom_range(0, 3), $urandom_range(0, 7) == 0);
        end
        idle_cycle();

        wait_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nebula_vc_credit_ctrl.md
Name: nebula_vc_credit_ctrl

Overview:
- Multi-VC, credit-based flow-control tracker for one NoC output link.
- Holds one credit counter per virtual channel, sized to the downstream VC buffer depth.
- Gates flit sends per VC and accepts batched credit returns of up to RET_MAX credits per cycle.
- Flags protocol violations and reports link-drained status; sits between the router output arbiter and the physical link.

Parameters:
- NUM_VCS, default NUM_VCS from nebula_pkg (4): number of virtual channels tracked.
- VC_CREDITS, default VC_DEPTH from nebula_pkg: initial and maximum credits per VC.
- RET_MAX, default 2: maximum credits returned in one cycle for one VC.
- CREDIT_WIDTH, default $clog2(VC_CREDITS+1): width of each counter (derived; do not override).
- VC_W, default $clog2(NUM_VCS) (minimum 1): VC index width (derived).
- RET_W, default $clog2(RET_MAX+1): return-count width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- send_valid  in  1  arbiter requests to send one flit.
- send_vc  in  VC_W  target VC of the send.
- send_accept  out  1  combinational: send_valid && credits[send_vc] > 0.
- ret_valid  in  1  credit return present.
- ret_vc  in  VC_W  VC receiving the returned credits.
- ret_cnt  in  RET_W  number of credits returned (0..RET_MAX).
- vc_avail  out  NUM_VCS  bit v = (credits[v] > 0).
- credit_count  out  NUM_VCS*CREDIT_WIDTH  packed counters; VC v at bits [v*CREDIT_WIDTH +: CREDIT_WIDTH].
- link_idle  out  1  registered: all counters == VC_CREDITS.
- err_underflow  out  1  sticky: send_valid seen on a VC with 0 credits.
- err_overflow  out  1  sticky: a return would exceed VC_CREDITS, or ret_cnt > RET_MAX, or send_vc/ret_vc >= NUM_VCS.
- err_clear  in  1  synchronous clear of both sticky error flags.
- stat_stall_cycles  out  32  stall counter (see Optional Feature).
- stat_flits_sent  out  32  sent-flit counter (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert):
  - every counter = VC_CREDITS, so vc_avail = all ones and link_idle = 1;
  - err flags = 0, stat counters = 0;
  - send_accept = 0, because send_valid is assumed low during reset.
- Per cycle, for each VC v: next = credits[v] - dec + inc.
  - dec = 1 if send_accept && send_vc == v.
  - inc = ret_cnt if ret_valid && ret_vc == v && ret_cnt <= RET_MAX, else 0.
  - Compute at CREDIT_WIDTH+RET_W+1 bits, with no wrap.
- Saturation: if next > VC_CREDITS, the counter becomes VC_CREDITS and err_overflow is set the next cycle.
- Simultaneous send and return on the same VC: net result in one cycle. Example: credits 0, send_valid, ret_cnt=1 → send_accept=0 (the decision uses the current count), next = 1.
- Send with credits[send_vc] == 0: no decrement, send_accept=0, err_underflow set. The upstream arbiter must treat this as a stall.
- Out-of-range send_vc (non-power-of-2 NUM_VCS): send_accept=0 and err_overflow set. Out-of-range ret_vc: the return is dropped and err_overflow set.
- ret_cnt == 0 with ret_valid: no-op, no error.
- err_clear has priority over a same-cycle error set: the flag reads 0 the next cycle, and a persisting condition sets it again the cycle after.
- Latency:
  - counter update visible on credit_count/vc_avail 1 cycle after the event;
  - link_idle is registered from the next-state counters, so it also lags by 1 cycle;
  - send_accept is zero-latency combinational.
- Reset mid-operation: all in-flight credit state is discarded and counters return to full. Resetting both link ends together is a system-level requirement.

Optional Feature:
- Macro: NEBULA_CREDIT_STATS_EN.
- Defined:
  - stat_stall_cycles increments each cycle send_valid && !send_accept;
  - stat_flits_sent increments on each send_accept;
  - both saturate at 32'hFFFF_FFFF and are cleared only by reset.
- Undefined: both ports are tied to 0 and no counter flops are inferred. Port list is identical in both builds.

Test Plan:
- All scenarios use NUM_VCS=4, VC_CREDITS=4, RET_MAX=2.
- Reset: credit_count = {4,4,4,4}, vc_avail = 4'b1111, link_idle = 1, errors 0.
- Drain VC2: 4 sends on VC2 → credit_count[2] = 0, vc_avail = 4'b1011, link_idle = 0. A 5th send → send_accept = 0 and err_underflow = 1 the next cycle.
- Same-cycle send+return: VC1 at 2, send VC1 plus ret VC1 cnt=2 → VC1 = 3. VC1 at 0, send+ret cnt=1 → accept=0, VC1 = 1.
- Overflow: VC0 at 3, ret cnt=2 → VC0 = 4 (clamped), err_overflow = 1. err_clear → 0 the next cycle.
- Independence: send VC3 plus ret VC0 cnt=1 in one cycle, VC0 at 3 → VC0 = 4, VC3 = 3, no errors.
- Stats (NEBULA_CREDIT_STATS_EN): 4 accepted sends then 3 blocked cycles on VC2 → stat_flits_sent = 4, stat_stall_cycles = 3. Without the macro, both read 0.
